// File: rtl/bus_rr_arbiter.sv
// Purpose: round-robin arbiter sharing one req/gnt/rvalid device port among NrHosts hosts.
// Latency: request reaches the device in the same cycle it is selected; the response is forwarded combinationally.
// Backpressure: the device stalls with dev_gnt_i low; losing hosts see no grant and keep their request raised.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset (all outputs forced to 0 while low)
//   host_*_i / host_*_o    per-host request side, flattened buses (host h at [h*W +: W])
//   dev_*_o / dev_*_i      single device side, one transaction in flight at a time
//   owner_o                selected host: combinational winner in IDLE, registered owner in REQ/WAIT
module bus_rr_arbiter #(
    parameter int unsigned NrHosts       = 2,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned TimeoutCycles = 16,
    localparam int unsigned IdxW         = (NrHosts > 1) ? $clog2(NrHosts) : 1,
    localparam int unsigned BeW          = DataWidth / 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NrHosts-1:0]              host_req_i,
    output logic [NrHosts-1:0]              host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0] host_addr_i,
    input  logic [NrHosts-1:0]              host_we_i,
    input  logic [NrHosts*BeW-1:0]          host_be_i,
    input  logic [NrHosts*DataWidth-1:0]    host_wdata_i,
    output logic [NrHosts-1:0]              host_rvalid_o,
    output logic [NrHosts-1:0]              host_err_o,
    output logic [DataWidth-1:0]            host_rdata_o,
    output logic                            dev_req_o,
    input  logic                            dev_gnt_i,
    output logic [AddressWidth-1:0]         dev_addr_o,
    output logic                            dev_we_o,
    output logic [BeW-1:0]                  dev_be_o,
    output logic [DataWidth-1:0]            dev_wdata_o,
    input  logic                            dev_rvalid_i,
    input  logic [DataWidth-1:0]            dev_rdata_i,
    input  logic                            dev_err_i,
    output logic [IdxW-1:0]                 owner_o
);

    // TimeoutCycles >= 2, so the counter only needs to reach TimeoutCycles-1.
    localparam int unsigned     CntW    = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Winner: first requesting host scanning rr_ptr+1, rr_ptr+2, ... modulo NrHosts.
    logic            win_vld;
    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] cand;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 1; i <= NrHosts; i++) begin
            cand = IdxW'((32'(rr_ptr_q) + i) % NrHosts);
            if (!win_vld && host_req_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // In IDLE the selection is live; once in REQ it is locked to owner_q.
    logic [IdxW-1:0] sel;
    logic            req_act;
    logic            rsp_vld;

    always_comb begin
        sel     = (state_q == IDLE) ? win_idx : owner_q;
        req_act = ((state_q == IDLE) && win_vld) || (state_q == REQ);
        // A real response and the timeout share the same delivery cycle; the real one wins below.
        rsp_vld = (state_q == WAIT) && (dev_rvalid_i || (cnt_q == CntLast));
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    owner_d = win_idx;
                    if (dev_gnt_i) begin
                        rr_ptr_d = win_idx;
                        state_d  = WAIT;
                    end else begin
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                if (dev_gnt_i) begin
                    rr_ptr_d = owner_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (rsp_vld) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= IdxW'(NrHosts - 1);
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs are gated by rst_ni so nothing leaks out while reset is held,
    // even though the IDLE request path is combinational from host_req_i.
    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        dev_req_o     = 1'b0;
        dev_addr_o    = '0;
        dev_we_o      = 1'b0;
        dev_be_o      = '0;
        dev_wdata_o   = '0;
        owner_o       = '0;
        if (rst_ni) begin
            owner_o = ((state_q == IDLE) && win_vld) ? win_idx : owner_q;
            if (req_act) begin
                dev_req_o       = 1'b1;
                dev_addr_o      = host_addr_i[32'(sel)*AddressWidth +: AddressWidth];
                dev_we_o        = host_we_i[sel];
                dev_be_o        = host_be_i[32'(sel)*BeW +: BeW];
                dev_wdata_o     = host_wdata_i[32'(sel)*DataWidth +: DataWidth];
                host_gnt_o[sel] = dev_gnt_i;
            end
            if (rsp_vld) begin
                host_rvalid_o[owner_q] = 1'b1;
                host_err_o[owner_q]    = dev_rvalid_i ? dev_err_i : 1'b1;
                host_rdata_o           = dev_rvalid_i ? dev_rdata_i : '0;
            end
        end
    end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
Round-robin host arbiter that shares one device port between NrHosts Ibex-style hosts (req/gnt/rvalid protocol).
- Supports devices with variable grant and response latency; one transaction in flight at a time.
- Includes a response timeout that returns a bus error.
- Sits between the core/DMA hosts and the address-decoding bus fabric (or a single slow device).

Parameters:
NrHosts, 2, number of requesting hosts (>=2).
DataWidth, 32, data bus width in bits.
AddressWidth, 32, address width in bits.
TimeoutCycles, 16, max cycles in WAIT before error response (>=2).

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset.
host_req_i  in  NrHosts  per-host request; held until grant.
host_gnt_o  out  NrHosts  per-host grant.
host_addr_i  in  NrHosts*AddressWidth  flattened addresses, host h at [h*AW +: AW].
host_we_i  in  NrHosts  write enables.
host_be_i  in  NrHosts*DataWidth/8  flattened byte enables.
host_wdata_i  in  NrHosts*DataWidth  flattened write data.
host_rvalid_o  out  NrHosts  per-host response valid.
host_err_o  out  NrHosts  per-host error, qualified by rvalid.
host_rdata_o  out  DataWidth  shared read data, valid for host whose rvalid is high.
dev_req_o  out  1  device request.
dev_gnt_i  in  1  device grant.
dev_addr_o  out  AddressWidth  device address.
dev_we_o  out  1  device write enable.
dev_be_o  out  DataWidth/8  device byte enables.
dev_wdata_o  out  DataWidth  device write data.
dev_rvalid_i  in  1  device response valid.
dev_rdata_i  in  DataWidth  device read data.
dev_err_i  in  1  device error.
owner_o  out  clog2(NrHosts) (min 1)  host index currently selected or awaiting response.

Behaviour:

States and reset:
- States are IDLE, REQ and WAIT.
- Reset: state IDLE, rr_ptr = NrHosts-1 (so host 0 wins first), owner = 0, timeout counter = 0.
- All outputs are 0 while in reset.

Selection:
- The winner is the first requesting host scanning rr_ptr+1, rr_ptr+2, ... modulo NrHosts.

IDLE:
- If any host_req_i is set, owner = winner combinationally.
- dev_req_o = 1 in the same cycle, and dev_* are driven from the owner's fields.
- host_gnt_o[owner] = dev_gnt_i.
- If dev_gnt_i = 1: register owner, set rr_ptr = owner, go to WAIT.
- If dev_gnt_i = 0: register owner, go to REQ.

REQ:
- The selection is locked: dev_req_o = 1 with the registered owner's fields, and later-arriving hosts are ignored.
- host_gnt_o[owner] = dev_gnt_i.
- On dev_gnt_i: set rr_ptr = owner, go to WAIT.

WAIT:
- dev_req_o = 0 and all host_gnt_o = 0.
- The counter increments every cycle.
- On dev_rvalid_i: host_rvalid_o[owner] = 1, host_err_o[owner] = dev_err_i, host_rdata_o = dev_rdata_i, all in the same cycle (combinational). Go to IDLE and clear the counter.
- Timeout: if the counter reaches TimeoutCycles-1 without dev_rvalid_i, assert host_rvalid_o[owner] = 1, host_err_o[owner] = 1, host_rdata_o = 0 for one cycle, then go to IDLE.
- If dev_rvalid_i and the timeout coincide, the real response wins.

Outputs in states without a valid response:
- dev_addr_o, dev_we_o, dev_be_o and dev_wdata_o are 0 whenever dev_req_o = 0.
- host_rdata_o = 0 and host_rvalid_o/host_err_o = 0 whenever no response is being delivered.

Boundary conditions:
- Stray or late dev_rvalid_i (in IDLE or REQ, including after a timeout) is ignored and not forwarded.
- No new grant in the response cycle; the earliest next dev_req_o is the cycle after leaving WAIT.
- Hence minimum per-transaction spacing is 2 cycles.
- A host dropping host_req_i in REQ is a protocol violation; behaviour stays locked and is not required to recover.
- Asynchronous reset mid-transaction returns to IDLE immediately and drops the pending response.
- owner_o shows the registered owner in REQ/WAIT and the combinational winner in IDLE.

Test Plan:
1. Single host 0 read, dev_gnt_i same cycle, dev_rvalid_i 3 cycles later with rdata 0xDEADBEEF -> host_gnt_o[0] pulses 1 cycle; host_rvalid_o[0] = 1 with host_rdata_o = 0xDEADBEEF, host_err_o = 0.
2. Hosts 0 and 1 request continuously, device always grants, responds in 1 cycle -> grants alternate 0,1,0,1; each host gets exactly 2 grants in 4 transactions.
3. Host 1 in REQ with dev_gnt_i held low for 5 cycles; host 0 raises request in cycle 2 -> dev_addr_o stays host 1 address throughout; host 1 granted first, host 0 next.
4. Grant then no dev_rvalid_i, TimeoutCycles = 16 -> host_rvalid_o[owner] = 1, host_err_o = 1, rdata 0 exactly 16 cycles after the grant cycle; a dev_rvalid_i 2 cycles later is not forwarded.
5. Device returns dev_err_i = 1 on response -> host_err_o[owner] = 1 with rvalid; rr_ptr still advances.
6. Assert rst_ni = 0 during WAIT -> all outputs 0 immediately; after release host 0 wins first against a simultaneous host 1 request.
